// File: rtl/ntt_pkg.sv
// ntt_pkg: shared FSM state type and derived-width helpers for the NTT stream adapter
package ntt_pkg;
  typedef enum logic [2:0] {LOAD, KICK, COMPUTE, FETCH, DRAIN} state_e;
  function automatic int word_w(input int coef_w);
    return 2 * coef_w;
  endfunction
  function automatic int row_words(input int log_core_count);
    return 1 << (log_core_count + 1);
  endfunction
  function automatic int log_rows(input int log_words, input int log_core_count);
    return log_words - log_core_count - 1;
  endfunction
endpackage

// File: rtl/ntt_row_serializer.sv
// ntt_row_serializer: holds one result row and streams its words out in ascending order
module ntt_row_serializer #(
  parameter int WORD_W    = 60,
  parameter int ROW_WORDS = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load_i,
  input  logic [ROW_WORDS*WORD_W-1:0] row_i,
  input  logic                        last_row_i,
  input  logic                        m_ready_i,
  output logic                        m_valid_o,
  output logic [WORD_W-1:0]           m_data_o,
  output logic                        m_last_o,
  output logic                        row_done_o
);
  localparam int KW = $clog2(ROW_WORDS);
  logic [ROW_WORDS*WORD_W-1:0] row_q;
  logic [KW-1:0]               k_q;
  logic                        valid_q;
  logic                        hs;
  logic                        last_k;
  assign hs         = valid_q && m_ready_i;
  assign last_k     = k_q == KW'(ROW_WORDS - 1);
  assign m_valid_o  = valid_q;
  assign m_data_o   = row_q[k_q*WORD_W +: WORD_W];
  assign m_last_o   = valid_q && last_k && last_row_i;
  assign row_done_o = hs && last_k;
  // word index and valid: start on row load, advance only on handshake, k wraps to 0 after the last word
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      k_q     <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      k_q     <= '0;
    end else if (hs) begin
      valid_q <= !last_k;
      k_q     <= k_q + 1'b1;
    end
  end
  // row register is pure datapath, captured when the processor read data is valid
  always_ff @(posedge clk) begin
    if (load_i) row_q <= row_i;
  end
endmodule

// File: rtl/ntt_stream_adapter.sv
// ntt_stream_adapter: streams a transform into the NTT processor and streams result rows back out; optional frame check under NTT_STREAM_ADAPTER_TLAST_CHECK_EN
module ntt_stream_adapter
  import ntt_pkg::*;
#(
  parameter  int COEF_W         = 30,
  parameter  int LOG_WORDS      = 11,
  parameter  int LOG_CORE_COUNT = 5,
  localparam int WORD_W         = word_w(COEF_W),
  localparam int ROW_WORDS      = row_words(LOG_CORE_COUNT),
  localparam int LOG_ROWS       = log_rows(LOG_WORDS, LOG_CORE_COUNT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WORD_W-1:0]           s_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [WORD_W-1:0]           m_data,
  output logic                        m_last,
  output logic                        proc_write_enable,
  output logic [LOG_WORDS-1:0]        proc_address_in,
  output logic [WORD_W-1:0]           proc_data_in,
  output logic                        proc_start,
  input  logic                        proc_done,
  output logic [LOG_ROWS-1:0]         proc_address_out,
  input  logic [ROW_WORDS*WORD_W-1:0] proc_out,
  output logic                        busy
`ifdef NTT_STREAM_ADAPTER_TLAST_CHECK_EN
  ,
  input  logic                        s_last,
  output logic                        frame_err
`endif
);
  state_e               state_q, state_d;
  logic [LOG_WORDS-1:0] load_q, load_d;
  logic [LOG_ROWS-1:0]  row_q, row_d;
  logic                 fetch_q, fetch_d;
  logic                 load_row;
  logic                 row_done;
  assign proc_address_in  = load_q;
  assign proc_data_in     = s_data;
  assign proc_address_out = row_q;
  assign busy             = !(state_q == LOAD && load_q == '0);
  // next-state and control outputs; FETCH spends one cycle addressing and one capturing the row
  always_comb begin
    state_d           = state_q;
    load_d            = load_q;
    row_d             = row_q;
    fetch_d           = 1'b0;
    s_ready           = 1'b0;
    proc_write_enable = 1'b0;
    proc_start        = 1'b0;
    load_row          = 1'b0;
    case (state_q)
      LOAD: begin
        s_ready           = rst_n;
        proc_write_enable = s_valid && rst_n;
        if (proc_write_enable) begin
          load_d  = load_q + 1'b1;
          state_d = &load_q ? KICK : LOAD;
        end
      end
      KICK: begin
        proc_start = 1'b1;
        state_d    = COMPUTE;
      end
      COMPUTE: begin
        row_d   = '0;
        state_d = proc_done ? FETCH : COMPUTE;
      end
      FETCH: begin
        fetch_d  = !fetch_q;
        load_row = fetch_q;
        state_d  = fetch_q ? DRAIN : FETCH;
      end
      DRAIN: begin
        if (row_done) begin
          row_d   = row_q + 1'b1;
          state_d = &row_q ? LOAD : FETCH;
        end
      end
      default: state_d = LOAD;
    endcase
  end
  // state and counters; reset discards any partial load or drain
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      load_q  <= '0;
      row_q   <= '0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      row_q   <= row_d;
      fetch_q <= fetch_d;
    end
  end
  ntt_row_serializer #(
    .WORD_W   (WORD_W),
    .ROW_WORDS(ROW_WORDS)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load_row),
    .row_i     (proc_out),
    .last_row_i(&row_q),
    .m_ready_i (m_ready),
    .m_valid_o (m_valid),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .row_done_o(row_done)
  );
`ifdef NTT_STREAM_ADAPTER_TLAST_CHECK_EN
  logic frame_q;
  assign frame_err = frame_q;
  // sticky error when s_last disagrees with whether this is the final word of the load
  always_ff @(posedge clk) begin
    if (!rst_n) frame_q <= 1'b0;
    else if (proc_write_enable && (s_last != &load_q)) frame_q <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_ntt_stream_adapter.sv
// tb_ntt_stream_adapter: directed checks of load, kick, drain, backpressure, reset abort and back-to-back transforms
module tb_ntt_stream_adapter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid;
  logic         s_ready;
  logic [59:0]  s_data;
  logic         m_valid;
  logic         m_ready;
  logic [59:0]  m_data;
  logic         m_last;
  logic         proc_write_enable;
  logic [4:0]   proc_address_in;
  logic [59:0]  proc_data_in;
  logic         proc_start;
  logic         proc_done;
  logic [2:0]   proc_address_out;
  logic [239:0] proc_out;
  logic         busy;
  logic         s_last;
  logic         frame_err;
  logic [59:0]  mem [32];
  int           dcnt;
  int           starts;
  int           checks;
  int           errors;
  always #5 clk = ~clk;
  ntt_stream_adapter #(.COEF_W(30), .LOG_WORDS(5), .LOG_CORE_COUNT(1)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_last           (m_last),
    .proc_write_enable(proc_write_enable),
    .proc_address_in  (proc_address_in),
    .proc_data_in     (proc_data_in),
    .proc_start       (proc_start),
    .proc_done        (proc_done),
    .proc_address_out (proc_address_out),
    .proc_out         (proc_out),
    .busy             (busy)
`ifdef NTT_STREAM_ADAPTER_TLAST_CHECK_EN
    ,
    .s_last           (s_last),
    .frame_err        (frame_err)
`endif
  );
`ifndef NTT_STREAM_ADAPTER_TLAST_CHECK_EN
  assign frame_err = 1'b0;
`endif
  always @(posedge clk) begin
    if (proc_write_enable) mem[proc_address_in] <= proc_data_in;
    for (int k = 0; k < 4; k++) proc_out[k*60 +: 60] <= mem[int'(proc_address_out)*4 + k];
    if (proc_start) starts <= starts + 1;
    if (!rst_n || proc_start) begin
      dcnt      <= 3;
      proc_done <= 1'b0;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) proc_done <= 1'b1;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic load(input int n, input int base, input int bad);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = {30'd0, 30'(base + i)};
      s_last  = (i == 31) ^ (i == bad);
      #1;
      chk("load_s_ready", s_ready, 1);
      chk("load_we", proc_write_enable, 1);
      chk("load_addr", proc_address_in, i);
      chk("load_data", proc_data_in, {30'd0, 30'(base + i)});
`ifdef NTT_STREAM_ADAPTER_TLAST_CHECK_EN
      chk("frame_err_load", frame_err, i > bad);
`endif
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
  endtask
  task automatic kick_check(input int exp_starts);
    chk("kick_start", proc_start, 1);
    chk("kick_s_ready", s_ready, 0);
    chk("kick_we", proc_write_enable, 0);
    @(negedge clk);
    #1;
    chk("kick_one_cycle", proc_start, 0);
    chk("start_count", starts, exp_starts);
  endtask
  task automatic drain(input int base, input bit tog);
    int idx = 0;
    int cyc = 0;
    int first = -1;
    bit stalled = 1'b0;
    logic [59:0] held = '0;
    while (idx < 32 && cyc < 600) begin
      @(negedge clk);
      m_ready = tog ? cyc[0] : 1'b1;
      #1;
      if (stalled) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, held);
      end
      stalled = m_valid && !m_ready;
      held    = m_data;
      if (m_valid && first < 0) first = cyc;
      if (m_valid && m_ready) begin
        chk("m_data", m_data, base + idx);
        chk("m_last", m_last, idx == 31);
        idx++;
      end
      cyc++;
    end
    chk("drain_complete", idx, 32);
    if (!tog) chk("drain_cycles", cyc - first, 46);
    @(negedge clk);
    m_ready = 1'b0;
    #1;
    chk("s_ready_after_drain", s_ready, 1);
    chk("m_valid_after_drain", m_valid, 0);
    chk("busy_after_drain", busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    checks  = 0;
    errors  = 0;
    starts  = 0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_s_ready", s_ready, 1);
    chk("rel_m_valid", m_valid, 0);
    chk("rel_m_last", m_last, 0);
    chk("rel_start", proc_start, 0);
    chk("rel_we", proc_write_enable, 0);
    chk("rel_busy", busy, 0);
    load(32, 0, 99);
    kick_check(1);
    drain(0, 1'b0);
    load(32, 100, 99);
    kick_check(2);
    drain(100, 1'b1);
    load(18, 200, 99);
    chk("partial_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_s_ready", s_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_s_ready_rel", s_ready, 1);
    repeat (5) @(negedge clk);
    chk("abort_no_start", starts, 2);
    load(32, 300, 99);
    kick_check(3);
    drain(300, 1'b0);
`ifdef NTT_STREAM_ADAPTER_TLAST_CHECK_EN
    chk("frame_err_clean", frame_err, 0);
    load(32, 400, 10);
    chk("frame_err_sticky", frame_err, 1);
    kick_check(4);
    drain(400, 1'b0);
    chk("frame_err_held", frame_err, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("frame_err_reset", frame_err, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ntt_stream_adapter.md
NTT_STREAM_ADAPTER -- requirements
Module: ntt_stream_adapter

Interface
REQ-001 SHALL have parameter COEF_W, default 30: coefficient width; WORD_W = 2*COEF_W (upper coefficient in upper half).
REQ-002 SHALL have parameter LOG_WORDS, default 11: words per transform = 2^LOG_WORDS.
REQ-003 SHALL have parameter LOG_CORE_COUNT, default 5: ROW_WORDS = 2^(LOG_CORE_COUNT+1); LOG_ROWS = LOG_WORDS-LOG_CORE_COUNT-1, which must be >= 1.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have ports s_valid / s_ready / s_data: input / output / input, 1 / 1 / WORD_W: input word stream.
REQ-007 SHALL have ports m_valid / m_ready / m_data / m_last: output / input / output / output, 1 / 1 / WORD_W / 1: result stream.
REQ-008 SHALL have ports proc_write_enable, proc_address_in, proc_data_in: output, output, output; widths 1, LOG_WORDS, WORD_W: processor load port.
REQ-009 SHALL have ports proc_start, proc_done: output, input, 1 each: processor start pulse and completion.
REQ-010 SHALL have ports proc_address_out, proc_out: output, input; widths LOG_ROWS, ROW_WORDS*WORD_W: result row read; word k at bits [k*WORD_W +: WORD_W], k = core*2+j.
REQ-011 SHALL have port busy, output, 1: high in every state except LOAD with load count 0.

Function
REQ-012 SHALL implement FSM LOAD -> KICK -> COMPUTE -> FETCH -> DRAIN, with DRAIN -> FETCH (more rows) or DRAIN -> LOAD (last row).
REQ-013 In LOAD, s_ready SHALL be 1; each s_valid&&s_ready SHALL drive proc_write_enable=1, proc_address_in=load count, proc_data_in=s_data in that same cycle (combinational pass-through).
REQ-014 The load count SHALL increment per accepted word; on acceptance of word 2^LOG_WORDS-1 the FSM SHALL go to KICK and the count SHALL wrap to 0.
REQ-015 KICK SHALL last exactly one cycle with proc_start=1, then go to COMPUTE.
REQ-016 COMPUTE SHALL wait for proc_done=1 (level-sampled); the row counter SHALL be 0 on entry to FETCH.
REQ-017 FETCH SHALL drive proc_address_out=row counter and SHALL capture proc_out into a row register on the next cycle (1-cycle read latency), then enter DRAIN.
REQ-018 DRAIN SHALL present word k of the row register with m_valid=1; k SHALL advance only on m_valid&&m_ready; m_valid SHALL never drop without a handshake.
REQ-019 m_last SHALL be 1 only for word ROW_WORDS-1 of row 2^LOG_ROWS-1.
REQ-020 s_ready SHALL be 0 outside LOAD; proc_write_enable SHALL be 0 outside LOAD.
REQ-021 Output order SHALL be row-major, k ascending within a row; throughput in DRAIN SHALL be one word per cycle when m_ready is held high; FETCH SHALL add exactly 2 bubble cycles per row.

Reset
REQ-022 rst_n=0 at any clock edge SHALL force LOAD with load/row/word counters 0 and s_ready=0 for that cycle; after release, s_ready=1, m_valid=0, m_last=0, proc_start=0, proc_write_enable=0, busy=0.
REQ-023 A reset mid-transform SHALL discard all partial state; no proc_start SHALL be issued for the aborted load.

Configuration
REQ-024 With macro NTT_STREAM_ADAPTER_TLAST_CHECK_EN defined, ports s_last (input, 1) and frame_err (output, 1, sticky until reset) SHALL exist; frame_err SHALL set if s_last=1 on a word other than the final one, or s_last=0 on the final one; the load proceeds regardless.
REQ-025 Without the macro, neither port SHALL exist and no check logic SHALL be built.

Structure
REQ-026 A shared package ntt_pkg SHALL hold the FSM state enum and the derived-width helper functions (WORD_W, ROW_WORDS, LOG_ROWS).
REQ-027 The serialiser (row register, word index, m_* handshake) SHALL be one sub-module, ntt_row_serializer.

Verification
REQ-028 Verification SHALL cover scenario V1: COEF_W=30, LOG_WORDS=5, LOG_CORE_COUNT=1, words i = {30'd0, i} for i=0..31 -> writes at addresses 0..31; one proc_start pulse one cycle after the word-31 handshake.
REQ-029 Verification SHALL cover scenario V2: with V1 params and a model processor returning row r word k = r*4+k -> m_data sequence 0..31; m_last only on 31.
REQ-030 Verification SHALL cover scenario V3: m_ready toggled 1/0 each cycle -> identical sequence; m_data stable while m_valid=1 and m_ready=0.
REQ-031 Verification SHALL cover scenario V4: rst_n=0 after word 17 is loaded, then a reload of 32 words -> proc_start only after the second load; busy=0 right after reset.
REQ-032 Verification SHALL cover scenario V5: with the macro defined, s_last=1 on word 10 -> frame_err=1 from the next cycle until reset; proc_start is still issued after word 31.
REQ-033 Verification SHALL cover scenario V6: two back-to-back transforms -> s_ready returns to 1 the cycle after the final m handshake; the second output sequence is correct.
